mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the CPU's single SRAM-like memory bus between the instruction-fetch port and the data (MEM-stage) port, with one outstanding transaction at a time. Produces `instructionStall` and `dataStall`, which feed the pipeline hazard unit. Applies the exception flush to in-flight fetches so wrong-path instructions are never delivered. Sits between the pipeline (fetch/MEM stages) and the cache/bridge interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request, level, held until inst_ok
- inst_addr  in  ADDR_W  fetch address, stable while inst_req
- inst_rdata  out  DATA_W  fetched word, valid with inst_ok
- inst_ok  out  1  one-cycle fetch completion
- data_req  in  1  load/store request, level, held until data_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data, valid with data_ok
- data_ok  out  1  one-cycle data completion
- flush  in  1  exception flush (from hazard `flushF`)
- bus_req, bus_wr  out  1  bus request / write
- bus_size  out  2  transfer size
- bus_addr  out  ADDR_W;  bus_wdata  out  DATA_W
- bus_addr_ok  in  1  address accepted when bus_req & bus_addr_ok
- bus_data_ok  in  1  response for the accepted transaction
- bus_rdata  in  DATA_W  read data, valid with bus_data_ok
- instructionStall, dataStall  out  1  stall requests to the hazard unit

## Operation
- FSM states: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT. Registers: state, last_grant (0 = inst, 1 = data), discard, latched bus_wr/bus_size/bus_addr/bus_wdata.
- IDLE: only data_req → D_ADDR; only inst_req → I_ADDR (flush low); both → the port not in last_grant (round robin). Granting latches the requester's fields and updates last_grant. Fetch latches bus_wr = 0, bus_size = 2.
- flush in IDLE blocks granting inst_req that cycle. A simultaneous data_req is still granted.
- X_ADDR: bus_req = 1. On bus_addr_ok → X_WAIT.
- X_WAIT: bus_req = 0. On bus_data_ok → IDLE. inst_ok or data_ok = 1 in that cycle, with rdata = bus_rdata (combinational pass-through).
- Flush, fetch side only:
  - I_ADDR with flush and no bus_addr_ok → IDLE, transaction dropped.
  - I_ADDR with flush and bus_addr_ok → I_WAIT with discard = 1.
  - I_WAIT with flush → discard = 1.
  - On bus_data_ok with discard = 1: inst_ok is suppressed and discard clears.
  - Data transactions are never cancelled.
- bus_data_ok in IDLE/X_ADDR is ignored.
- Stalls are combinational: instructionStall = inst_req & ~inst_ok; dataStall = data_req & ~data_ok.
- Bus outputs stay stable from grant until bus_addr_ok.

## Timing
- Reset (async, resetn low): state = IDLE, last_grant = 0, discard = 0. All bus_* outputs 0, inst_ok = data_ok = 0, rdata outputs 0 registered portion. Reset mid-transaction abandons the bus transaction without waiting for data_ok.
- Minimum latency: request seen in cycle 0, bus_req in cycle 1. With bus_addr_ok in cycle 1 and bus_data_ok in cycle 2, the ok pulse is in cycle 2 and IDLE is re-entered in cycle 3. That is 3 cycles per transaction, 2 stall cycles.
- Back-to-back: a requester that raises a new request in the cycle after ok is granted in that cycle if it wins arbitration.
- Starvation bound: with both ports continuously requesting, grants alternate D, I, D, I…
- The fetch ok pulse is never asserted in a cycle where flush = 1.

## Test plan
- Reset, then fetch at 0xBFC00000, bus_addr_ok in cycle 1, bus_data_ok in cycle 2 with rdata 0x24080001 → inst_ok in cycle 2, inst_rdata = 0x24080001, instructionStall high in cycles 0–1.
- Simultaneous inst_req and data_req (store word 0xDEADBEEF to 0x80000010, size 2) after reset → data granted first (bus_wr = 1, bus_addr = 0x80000010), inst second; dataStall and instructionStall deassert in their respective ok cycles.
- Both ports requesting continuously for 6 transactions → bus grant order D, I, D, I, D, I.
- Fetch accepted (I_WAIT), flush pulsed, bus_data_ok 3 cycles later → no inst_ok, FSM returns to IDLE, next fetch to 0xBFC00380 completes normally.
- Flush while in I_ADDR with bus_addr_ok low → IDLE next cycle, bus_req drops, no bus_data_ok expected.
- resetn deasserted asynchronously while in D_WAIT → bus_req, data_ok, and both stalls low immediately; a stale bus_data_ok afterwards produces no ok.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// mem_bus_arbiter_if : pipeline fetch/data ports and SRAM-like bus bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_ok;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_ok;

    logic              flush;

    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    logic              instructionStall;
    logic              dataStall;

    // Arbiter side: owns the bus, answers the pipeline
    modport master (
        input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr,
               data_wdata, flush, bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_rdata, inst_ok, data_rdata, data_ok, bus_req, bus_wr,
               bus_size, bus_addr, bus_wdata, instructionStall, dataStall
    );

    // Environment side: pipeline requesters plus bus responder
    modport slave (
        output inst_req, inst_addr, data_req, data_wr, data_size, data_addr,
               data_wdata, flush, bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_rdata, inst_ok, data_rdata, data_ok, bus_req, bus_wr,
               bus_size, bus_addr, bus_wdata, instructionStall, dataStall
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : round-robin fetch/data arbiter for a single-outstanding bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    mem_bus_arbiter_if.master    arb
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IADDR = 3'd1,
        S_IWAIT = 3'd2,
        S_DADDR = 3'd3,
        S_DWAIT = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_lastGrant;
    logic              r_discard;
    logic              w_nextDiscard;
    logic              r_busWr;
    logic [1:0]        r_busSize;
    logic [ADDR_W-1:0] r_busAddr;
    logic [DATA_W-1:0] r_busWdata;

    logic              w_instEligible;
    logic              w_grantInst;
    logic              w_grantData;
    logic              w_busReq;
    logic              w_instOk;
    logic              w_dataOk;

    // A flush in the grant cycle means the pending fetch is already wrong-path
    assign w_instEligible = arb.inst_req & ~arb.flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_lastGrant <= 1'b0;
            r_discard   <= 1'b0;
            r_busWr     <= 1'b0;
            r_busSize   <= 2'd0;
            r_busAddr   <= '0;
            r_busWdata  <= '0;
        end else begin
            r_state   <= w_nextState;
            r_discard <= w_nextDiscard;
            if (w_grantData) begin
                r_lastGrant <= 1'b1;
                r_busWr     <= arb.data_wr;
                r_busSize   <= arb.data_size;
                r_busAddr   <= arb.data_addr;
                r_busWdata  <= arb.data_wdata;
            end else if (w_grantInst) begin
                r_lastGrant <= 1'b0;
                r_busWr     <= 1'b0;
                r_busSize   <= 2'd2;
                r_busAddr   <= arb.inst_addr;
                r_busWdata  <= '0;
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextDiscard = r_discard;
        w_grantInst   = 1'b0;
        w_grantData   = 1'b0;
        w_busReq      = 1'b0;
        w_instOk      = 1'b0;
        w_dataOk      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Data wins unless fetch is also eligible and data went last
                if (arb.data_req && (!w_instEligible || !r_lastGrant)) begin
                    w_grantData = 1'b1;
                    w_nextState = S_DADDR;
                end else if (w_instEligible) begin
                    w_grantInst = 1'b1;
                    w_nextState = S_IADDR;
                end
            end
            S_IADDR: begin
                w_busReq = 1'b1;
                if (arb.bus_addr_ok) begin
                    w_nextState   = S_IWAIT;
                    w_nextDiscard = arb.flush;
                end else if (arb.flush) begin
                    w_nextState = S_IDLE;
                end
            end
            S_IWAIT: begin
                if (arb.bus_data_ok) begin
                    w_instOk      = ~r_discard & ~arb.flush;
                    w_nextState   = S_IDLE;
                    w_nextDiscard = 1'b0;
                end else if (arb.flush) begin
                    w_nextDiscard = 1'b1;
                end
            end
            S_DADDR: begin
                w_busReq = 1'b1;
                if (arb.bus_addr_ok) begin
                    w_nextState = S_DWAIT;
                end
            end
            S_DWAIT: begin
                if (arb.bus_data_ok) begin
                    w_dataOk    = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign arb.bus_req   = w_busReq;
    assign arb.bus_wr    = r_busWr;
    assign arb.bus_size  = r_busSize;
    assign arb.bus_addr  = r_busAddr;
    assign arb.bus_wdata = r_busWdata;

    assign arb.inst_ok    = w_instOk;
    assign arb.data_ok    = w_dataOk;
    assign arb.inst_rdata = w_instOk ? arb.bus_rdata : '0;
    assign arb.data_rdata = w_dataOk ? arb.bus_rdata : '0;

    // Stalls drop the instant reset asserts so the hazard unit never sees stale holds
    assign arb.instructionStall = resetn & arb.inst_req & ~w_instOk;
    assign arb.dataStall        = resetn & arb.data_req & ~w_dataOk;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed + randomized checks against a transaction model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .arb    (ifc)
    );

    int nCmp  = 0;
    int nFail = 0;
    bit cmpEn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one record for the single outstanding transfer
    bit          mActive, mIsData, mIssued, mSquash, mLastData;
    logic        mWr;
    logic [1:0]  mSize;
    logic [31:0] mAddr, mWdata;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mActive   <= 1'b0;
            mIssued   <= 1'b0;
            mSquash   <= 1'b0;
            mLastData <= 1'b0;
        end else if (!mActive) begin
            if (ifc.data_req && !(ifc.inst_req && !ifc.flush && mLastData)) begin
                mActive <= 1'b1; mIsData <= 1'b1; mIssued <= 1'b0; mSquash <= 1'b0;
                mLastData <= 1'b1;
                mWr <= ifc.data_wr; mSize <= ifc.data_size;
                mAddr <= ifc.data_addr; mWdata <= ifc.data_wdata;
            end else if (ifc.inst_req && !ifc.flush) begin
                mActive <= 1'b1; mIsData <= 1'b0; mIssued <= 1'b0; mSquash <= 1'b0;
                mLastData <= 1'b0;
                mWr <= 1'b0; mSize <= 2'd2; mAddr <= ifc.inst_addr; mWdata <= 32'd0;
            end
        end else if (!mIssued) begin
            if (ifc.bus_addr_ok) begin
                mIssued <= 1'b1;
                mSquash <= !mIsData && ifc.flush;
            end else if (!mIsData && ifc.flush) begin
                mActive <= 1'b0;
            end
        end else begin
            if (ifc.bus_data_ok) begin
                mActive <= 1'b0;
                mSquash <= 1'b0;
            end else if (!mIsData && ifc.flush) begin
                mSquash <= 1'b1;
            end
        end
    end

    function automatic bit expBusReq();
        return mActive && !mIssued;
    endfunction

    function automatic bit expIok();
        return mActive && mIssued && !mIsData && ifc.bus_data_ok && !mSquash && !ifc.flush;
    endfunction

    function automatic bit expDok();
        return mActive && mIssued && mIsData && ifc.bus_data_ok;
    endfunction

    always @(negedge clk) begin
        if (cmpEn) begin
            chk("bus_req", ifc.bus_req, expBusReq());
            if (expBusReq()) begin
                chk("bus_addr", ifc.bus_addr, mAddr);
                chk("bus_wr", ifc.bus_wr, mWr);
                chk("bus_size", ifc.bus_size, mSize);
                chk("bus_wdata", ifc.bus_wdata, mWdata);
            end
            chk("inst_ok", ifc.inst_ok, expIok());
            chk("data_ok", ifc.data_ok, expDok());
            chk("inst_rdata", ifc.inst_rdata, expIok() ? ifc.bus_rdata : 32'd0);
            chk("data_rdata", ifc.data_rdata, expDok() ? ifc.bus_rdata : 32'd0);
            chk("instructionStall", ifc.instructionStall, resetn && ifc.inst_req && !expIok());
            chk("dataStall", ifc.dataStall, resetn && ifc.data_req && !expDok());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ifc.inst_req = 1'b0; ifc.inst_addr = 32'd0;
        ifc.data_req = 1'b0; ifc.data_wr = 1'b0; ifc.data_size = 2'd0;
        ifc.data_addr = 32'd0; ifc.data_wdata = 32'd0;
        ifc.flush = 1'b0;
        ifc.bus_addr_ok = 1'b0; ifc.bus_data_ok = 1'b0; ifc.bus_rdata = 32'd0;
    endtask

    task automatic doReset();
        clearInputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    logic [31:0] grants[$];
    bit pending, hs, iok, dok;

    initial begin
        // Reset state
        doReset();
        cmpEn = 1'b1;
        @(negedge clk);
        chk("rst bus_req", ifc.bus_req, 1'b0);
        chk("rst bus_addr", ifc.bus_addr, 32'd0);
        chk("rst bus_wr", ifc.bus_wr, 1'b0);
        chk("rst bus_size", ifc.bus_size, 2'd0);
        chk("rst inst_ok", ifc.inst_ok, 1'b0);
        chk("rst data_ok", ifc.data_ok, 1'b0);

        // Minimum-latency fetch
        step();
        ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC00000; ifc.bus_addr_ok = 1'b1;
        @(negedge clk);
        chk("t1 istall c0", ifc.instructionStall, 1'b1);
        chk("t1 bus_req c0", ifc.bus_req, 1'b0);
        step();
        @(negedge clk);
        chk("t1 bus_req c1", ifc.bus_req, 1'b1);
        chk("t1 bus_addr c1", ifc.bus_addr, 32'hBFC00000);
        chk("t1 istall c1", ifc.instructionStall, 1'b1);
        step();
        ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h24080001;
        @(negedge clk);
        chk("t1 inst_ok c2", ifc.inst_ok, 1'b1);
        chk("t1 inst_rdata c2", ifc.inst_rdata, 32'h24080001);
        chk("t1 istall c2", ifc.instructionStall, 1'b0);
        step();
        ifc.inst_req = 1'b0; ifc.bus_data_ok = 1'b0;

        // Simultaneous requests: data first after reset
        doReset();
        ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC00004;
        ifc.data_req = 1'b1; ifc.data_wr = 1'b1; ifc.data_size = 2'd2;
        ifc.data_addr = 32'h80000010; ifc.data_wdata = 32'hDEADBEEF;
        ifc.bus_addr_ok = 1'b1;
        @(negedge clk);
        chk("t2 dstall c0", ifc.dataStall, 1'b1);
        step();
        @(negedge clk);
        chk("t2 bus_wr", ifc.bus_wr, 1'b1);
        chk("t2 bus_addr D", ifc.bus_addr, 32'h80000010);
        chk("t2 bus_wdata", ifc.bus_wdata, 32'hDEADBEEF);
        step();
        ifc.bus_data_ok = 1'b1;
        @(negedge clk);
        chk("t2 data_ok", ifc.data_ok, 1'b1);
        chk("t2 dstall ok", ifc.dataStall, 1'b0);
        chk("t2 istall held", ifc.instructionStall, 1'b1);
        step();
        ifc.data_req = 1'b0; ifc.bus_data_ok = 1'b0;
        step();
        @(negedge clk);
        chk("t2 bus_addr I", ifc.bus_addr, 32'hBFC00004);
        chk("t2 bus_wr I", ifc.bus_wr, 1'b0);
        step();
        ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h12345678;
        @(negedge clk);
        chk("t2 inst_ok", ifc.inst_ok, 1'b1);
        chk("t2 istall ok", ifc.instructionStall, 1'b0);
        step();
        ifc.inst_req = 1'b0; ifc.bus_data_ok = 1'b0;

        // Continuous requests: grant order alternates D, I, D, I, D, I
        doReset();
        ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC00100;
        ifc.data_req = 1'b1; ifc.data_size = 2'd2; ifc.data_addr = 32'h80000100;
        ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hA5A5A5A5;
        grants.delete();
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (ifc.bus_req && ifc.bus_addr_ok) grants.push_back(ifc.bus_addr);
            step();
        end
        chk("t3 grant count", (grants.size() >= 6), 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k < grants.size())
                chk($sformatf("t3 grant %0d", k), grants[k], (k % 2 == 0) ? 32'h80000100 : 32'hBFC00100);
        end
        clearInputs();

        // Flush while fetch is waiting for data
        doReset();
        ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC00200; ifc.bus_addr_ok = 1'b1;
        step();
        step();
        ifc.flush = 1'b1; ifc.inst_req = 1'b0;
        step();
        ifc.flush = 1'b0; ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC00380;
        step();
        step();
        ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t4 suppressed ok", ifc.inst_ok, 1'b0);
        chk("t4 istall", ifc.instructionStall, 1'b1);
        step();
        ifc.bus_data_ok = 1'b0;
        @(negedge clk);
        chk("t4 idle bus_req", ifc.bus_req, 1'b0);
        step();
        @(negedge clk);
        chk("t4 refetch req", ifc.bus_req, 1'b1);
        chk("t4 refetch addr", ifc.bus_addr, 32'hBFC00380);
        step();
        ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h3C1A8000;
        @(negedge clk);
        chk("t4 refetch ok", ifc.inst_ok, 1'b1);
        chk("t4 refetch rdata", ifc.inst_rdata, 32'h3C1A8000);
        step();
        clearInputs();

        // Flush in address phase without acceptance drops the fetch
        doReset();
        ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC00400;
        step();
        ifc.flush = 1'b1;
        @(negedge clk);
        chk("t5 bus_req before", ifc.bus_req, 1'b1);
        step();
        ifc.flush = 1'b0; ifc.inst_req = 1'b0;
        @(negedge clk);
        chk("t5 bus_req dropped", ifc.bus_req, 1'b0);
        step();

        // Asynchronous reset during data wait
        doReset();
        ifc.data_req = 1'b1; ifc.data_addr = 32'h80000020; ifc.bus_addr_ok = 1'b1;
        step();
        step();
        ifc.bus_addr_ok = 1'b0;
        @(negedge clk);
        chk("t6 waiting dstall", ifc.dataStall, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("t6 rst bus_req", ifc.bus_req, 1'b0);
        chk("t6 rst data_ok", ifc.data_ok, 1'b0);
        chk("t6 rst dstall", ifc.dataStall, 1'b0);
        chk("t6 rst istall", ifc.instructionStall, 1'b0);
        ifc.bus_data_ok = 1'b1;
        #1;
        chk("t6 rst stale ok", ifc.data_ok, 1'b0);
        step();
        ifc.data_req = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        chk("t6 stale data_ok", ifc.data_ok, 1'b0);
        chk("t6 stale inst_ok", ifc.inst_ok, 1'b0);
        step();
        ifc.bus_data_ok = 1'b0;

        // Randomized traffic against the model
        doReset();
        pending = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            hs  = ifc.bus_req && ifc.bus_addr_ok;
            iok = ifc.inst_ok;
            dok = ifc.data_ok;
            step();
            if (ifc.bus_data_ok && pending) pending = 1'b0;
            if (hs) pending = 1'b1;
            ifc.bus_addr_ok = ($urandom_range(0, 1) == 1);
            ifc.bus_data_ok = pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            ifc.bus_rdata   = $urandom;
            ifc.flush       = ($urandom_range(0, 9) == 0);
            if (iok) ifc.inst_req = 1'b0;
            if (ifc.flush && ifc.inst_req && $urandom_range(0, 1) == 0) ifc.inst_req = 1'b0;
            if (!ifc.inst_req && $urandom_range(0, 2) == 0) begin
                ifc.inst_req  = 1'b1;
                ifc.inst_addr = $urandom & 32'hFFFFFFFC;
            end
            if (dok) ifc.data_req = 1'b0;
            if (!ifc.data_req && $urandom_range(0, 2) == 0) begin
                ifc.data_req   = 1'b1;
                ifc.data_wr    = $urandom_range(0, 1);
                ifc.data_size  = 2'($urandom_range(0, 2));
                ifc.data_addr  = $urandom;
                ifc.data_wdata = $urandom;
            end
        end

        cmpEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

`default_nettype wire
